// File: rtl/alu_ctrl_unit.sv
// Registered MIPS ALU control decoder: maps opcode/funct to an ALU operation
// select, register-file write enable and an illegal-instruction flag (1-cycle latency).
module alu_ctrl_unit #(
  parameter int CTRL_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [5:0]        opcode,
  input  logic [5:0]        func_field,
  output logic [CTRL_W-1:0] ALU_ctrl,
  output logic              reg_write,
  output logic              illegal
);

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011,
    OP_BEQ   = 6'b000100,
    OP_ADDI  = 6'b001000,
    OP_ANDI  = 6'b001100,
    OP_ORI   = 6'b001101,
    OP_SLTI  = 6'b001010
  } opcode_e;

  typedef enum logic [5:0] {
    FN_ADD  = 6'b100000,
    FN_ADDU = 6'b100001,
    FN_SUB  = 6'b100010,
    FN_SUBU = 6'b100011,
    FN_AND  = 6'b100100,
    FN_OR   = 6'b100101,
    FN_SLT  = 6'b101010
  } funct_e;

  alu_op_e op_d;
  logic    rw_d;
  logic    ill_d;

  always_comb begin
    // NOTE: every output gets a default first so no path through the cases
    // leaves a variable unassigned, which would infer a latch.
    op_d  = ALU_ADD;
    rw_d  = 1'b0;
    ill_d = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        rw_d = 1'b1;
        case (func_field)
          FN_ADD, FN_ADDU: op_d = ALU_ADD;
          FN_SUB, FN_SUBU: op_d = ALU_SUB;
          FN_AND:          op_d = ALU_AND;
          FN_OR:           op_d = ALU_OR;
          FN_SLT:          op_d = ALU_SLT;
          default: begin
            rw_d  = 1'b0;
            ill_d = 1'b1;
          end
        endcase
      end
      OP_LW:   rw_d = 1'b1;
      OP_SW:   rw_d = 1'b0;
      OP_BEQ:  op_d = ALU_SUB;
      OP_ADDI: rw_d = 1'b1;
      OP_ANDI: begin op_d = ALU_AND; rw_d = 1'b1; end
      OP_ORI:  begin op_d = ALU_OR;  rw_d = 1'b1; end
      OP_SLTI: begin op_d = ALU_SLT; rw_d = 1'b1; end
      default: ill_d = 1'b1;  // unsupported opcode still drives a defined ADD
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      ALU_ctrl  <= '0;
      reg_write <= 1'b0;
      illegal   <= 1'b0;
    end else if (en) begin
      ALU_ctrl  <= CTRL_W'(op_d);
      reg_write <= rw_d;
      illegal   <= ill_d;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_unit.sv
// Scoreboard bench for alu_ctrl_unit: directed and random stimulus, expected
// results from a table-driven reference model, checked by an independent monitor.
module tb_alu_ctrl_unit;

  typedef struct packed {
    logic [2:0] ctrl;
    logic       rw;
    logic       ill;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [5:0] opcode;
  logic [5:0] func_field;
  logic [2:0] ALU_ctrl;
  logic       reg_write;
  logic       illegal;

  int pass_cnt  = 0;
  int total_cnt = 0;

  exp_t exp_q[$];
  exp_t model_out;

  exp_t rtype_tbl[logic [5:0]];
  exp_t itype_tbl[logic [5:0]];

  logic [5:0] op_list[7] = '{6'b100011, 6'b101011, 6'b000100, 6'b001000,
                             6'b001100, 6'b001101, 6'b001010};
  logic [5:0] fn_list[7] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011,
                             6'b100100, 6'b100101, 6'b101010};

  alu_ctrl_unit #(.CTRL_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .opcode     (opcode),
    .func_field (func_field),
    .ALU_ctrl   (ALU_ctrl),
    .reg_write  (reg_write),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input exp_t act, input exp_t exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got ctrl=%b rw=%b ill=%b, expected ctrl=%b rw=%b ill=%b",
               name, act.ctrl, act.rw, act.ill, exp.ctrl, exp.rw, exp.ill);
    else
      pass_cnt++;
  endtask

  function automatic exp_t decode(input logic [5:0] op, input logic [5:0] fn);
    exp_t bad;
    bad = '{ctrl: 3'b010, rw: 1'b0, ill: 1'b1};
    if (op == 6'b000000)
      return rtype_tbl.exists(fn) ? rtype_tbl[fn] : bad;
    return itype_tbl.exists(op) ? itype_tbl[op] : bad;
  endfunction

  function automatic exp_t dut_out();
    return '{ctrl: ALU_ctrl, rw: reg_write, ill: illegal};
  endfunction

  // Drive one edge's worth of inputs at the falling edge and predict the result.
  task automatic step(input logic [5:0] op, input logic [5:0] fn,
                      input logic e, input logic r);
    @(negedge clk);
    opcode     = op;
    func_field = fn;
    en         = e;
    rst_n      = r;
    if (!r)     model_out = '0;
    else if (e) model_out = decode(op, fn);
    exp_q.push_back(model_out);
  endtask

  // Monitor: each edge that had stimulus issued is compared one tick later.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) check("edge_out", dut_out(), exp_q.pop_front());
    end
  end

  initial begin
    logic [5:0] op, fn;
    int         r;

    rtype_tbl[6'b100000] = '{3'b010, 1'b1, 1'b0};
    rtype_tbl[6'b100001] = '{3'b010, 1'b1, 1'b0};
    rtype_tbl[6'b100010] = '{3'b110, 1'b1, 1'b0};
    rtype_tbl[6'b100011] = '{3'b110, 1'b1, 1'b0};
    rtype_tbl[6'b100100] = '{3'b000, 1'b1, 1'b0};
    rtype_tbl[6'b100101] = '{3'b001, 1'b1, 1'b0};
    rtype_tbl[6'b101010] = '{3'b111, 1'b1, 1'b0};
    itype_tbl[6'b100011] = '{3'b010, 1'b1, 1'b0};
    itype_tbl[6'b101011] = '{3'b010, 1'b0, 1'b0};
    itype_tbl[6'b000100] = '{3'b110, 1'b0, 1'b0};
    itype_tbl[6'b001000] = '{3'b010, 1'b1, 1'b0};
    itype_tbl[6'b001100] = '{3'b000, 1'b1, 1'b0};
    itype_tbl[6'b001101] = '{3'b001, 1'b1, 1'b0};
    itype_tbl[6'b001010] = '{3'b111, 1'b1, 1'b0};

    rst_n = 1'b0; en = 1'b1; opcode = 6'b000000; func_field = 6'b100000;
    model_out = '0;
    #2;
    check("reset_immediate", dut_out(), '0);

    repeat (3) step(6'b000000, 6'b100000, 1'b1, 1'b0);

    // R-type sweep
    step(6'b000000, 6'b100000, 1'b1, 1'b1);
    step(6'b000000, 6'b100010, 1'b1, 1'b1);
    step(6'b000000, 6'b100100, 1'b1, 1'b1);
    step(6'b000000, 6'b100101, 1'b1, 1'b1);
    step(6'b000000, 6'b101010, 1'b1, 1'b1);
    step(6'b000000, 6'b100001, 1'b1, 1'b1);
    step(6'b000000, 6'b100011, 1'b1, 1'b1);

    // I-type / memory
    step(6'b100011, 6'b000000, 1'b1, 1'b1);
    step(6'b101011, 6'b111111, 1'b1, 1'b1);
    step(6'b000100, 6'b100000, 1'b1, 1'b1);
    step(6'b001101, 6'b000000, 1'b1, 1'b1);
    step(6'b001000, 6'b000000, 1'b1, 1'b1);
    step(6'b001100, 6'b000000, 1'b1, 1'b1);
    step(6'b001010, 6'b000000, 1'b1, 1'b1);

    // Illegal encodings
    step(6'b000000, 6'b000000, 1'b1, 1'b1);
    step(6'b111111, 6'b100000, 1'b1, 1'b1);

    // Enable hold
    step(6'b000000, 6'b100010, 1'b1, 1'b1);
    repeat (3) step(6'b000000, 6'b100100, 1'b0, 1'b1);
    step(6'b000000, 6'b100100, 1'b1, 1'b1);

    // Latency: change inputs just after an edge, outputs must not move yet
    step(6'b000000, 6'b100101, 1'b1, 1'b1);
    @(posedge clk);
    #2;
    opcode = 6'b111111;
    #2;
    check("latency_hold", dut_out(), '{3'b001, 1'b1, 1'b0});

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4)      op = 6'b000000;
      else if (r < 8) op = op_list[$urandom_range(0, 6)];
      else            op = 6'($urandom);
      fn = ($urandom_range(0, 9) < 6) ? fn_list[$urandom_range(0, 6)] : 6'($urandom);
      step(op, fn, ($urandom_range(0, 3) != 0), 1'b1);
    end

    // Mid-operation asynchronous reset between edges
    step(6'b000000, 6'b100010, 1'b1, 1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_mid", dut_out(), '0);
    model_out = '0;
    step(6'b001101, 6'b000000, 1'b1, 1'b0);
    step(6'b001101, 6'b000000, 1'b1, 1'b1);
    step(6'b000000, 6'b101010, 1'b1, 1'b1);

    for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(posedge clk);
    #3;
    total_cnt++;
    if (exp_q.size() != 0)
      $display("FAIL drain: %0d expected results never compared, required 0", exp_q.size());
    else
      pass_cnt++;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
